// File: rtl/spi_master.sv
// Byte-wide SPI mode-0 master with TX/RX FIFOs on the BIU proxy bus (window 0x2).
// Optional loopback enabled by defining SPI_MASTER_LOOPBACK_EN.
module spi_master #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [3:0] DIV_RESET  = 4'h3
) (
  input  logic       CORE_CLK,
  input  logic       RST_n,
  input  logic [3:0] ADDRESS,
  input  logic [7:0] DATA_IN,
  output logic [7:0] DATA_OUT,
  input  logic       STROBE_WR,
  input  logic       STROBE_RD,
  output logic       SPI_SCLK,
  output logic       SPI_MOSI,
  input  logic       SPI_MISO,
  output logic       SPI_CS_n,
  output logic       SPI_INT
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, LOW, HIGH} state_e;

  state_e      state_q, state_d;
  logic [7:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_hold_q, rx_hold_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  hcnt_q, hcnt_d, div_lat_q, div_lat_d, div_q, div_d;
  logic        sclk_q, sclk_d, mosi_q, mosi_d, cs_q, cs_d, int_en_q, int_en_d;
  logic        tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d, int_q, int_d;
  logic [AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [AW:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [7:0]  rx_mem [FIFO_DEPTH];

  logic tx_empty, tx_full, rx_empty, rx_full, busy, miso_in;
  logic wr_data, rd_data, tx_push, tx_pop, rx_push, rx_pop, rx_req;
  logic loop_bit;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic loop_q, loop_d;
  assign loop_bit = loop_q;
  assign miso_in  = loop_q ? mosi_q : SPI_MISO;
  assign SPI_SCLK = sclk_q & ~loop_q;
  assign SPI_MOSI = mosi_q & ~loop_q;
  assign SPI_CS_n = ~cs_q | loop_q;
`else
  assign loop_bit = 1'b0;
  assign miso_in  = SPI_MISO;
  assign SPI_SCLK = sclk_q;
  assign SPI_MOSI = mosi_q;
  assign SPI_CS_n = ~cs_q;
`endif
  assign SPI_INT = int_q;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign busy     = (state_q != IDLE) || !tx_empty;

  always_comb begin
    case (ADDRESS)
      4'h0:    DATA_OUT = rx_hold_q;
      4'h1:    DATA_OUT = {1'b0, rx_ovf_q, tx_ovf_q, rx_full, rx_empty, tx_empty, tx_full, busy};
      4'h2:    DATA_OUT = {loop_bit, int_en_q, 2'b00, div_q};
      4'h3:    DATA_OUT = {7'b0, cs_q};
      default: DATA_OUT = 8'hEE;
    endcase
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d = state_q;  tx_sh_d = tx_sh_q;  rx_sh_d = rx_sh_q;  rx_hold_d = rx_hold_q;
    bit_cnt_d = bit_cnt_q;  hcnt_d = hcnt_q;  div_lat_d = div_lat_q;  div_d = div_q;
    sclk_d = sclk_q;  mosi_d = mosi_q;  cs_d = cs_q;  int_en_d = int_en_q;
    tx_ovf_d = tx_ovf_q;  rx_ovf_d = rx_ovf_q;
`ifdef SPI_MASTER_LOOPBACK_EN
    loop_d = loop_q;
`endif
    rx_req = 1'b0;

    wr_data = STROBE_WR && (ADDRESS == 4'h0);
    rd_data = STROBE_RD && (ADDRESS == 4'h0);
    tx_pop  = (state_q == LOAD);
    tx_push = wr_data && (!tx_full || tx_pop);
    rx_pop  = rd_data && !rx_empty;

    case (state_q)
      IDLE: if (!tx_empty) state_d = LOAD;
      LOAD: begin
        tx_sh_d   = tx_mem[tx_rptr_q];
        mosi_d    = tx_mem[tx_rptr_q][7];
        bit_cnt_d = 3'd7;
        div_lat_d = div_q;
        hcnt_d    = div_q;
        sclk_d    = 1'b0;
        state_d   = LOW;
      end
      LOW: begin
        if (hcnt_q == 4'd0) begin
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso_in};
          hcnt_d  = div_lat_q;
          state_d = HIGH;
        end else begin
          hcnt_d = hcnt_q - 4'd1;
        end
      end
      HIGH: begin
        if (hcnt_q == 4'd0) begin
          sclk_d = 1'b0;
          hcnt_d = div_lat_q;
          if (bit_cnt_q != 3'd0) begin
            bit_cnt_d = bit_cnt_q - 3'd1;
            tx_sh_d   = {tx_sh_q[6:0], 1'b0};
            mosi_d    = tx_sh_q[6];
            state_d   = LOW;
          end else begin
            rx_req  = 1'b1;
            state_d = tx_empty ? IDLE : LOAD;
          end
        end else begin
          hcnt_d = hcnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    rx_push = rx_req && (!rx_full || rx_pop);

    if (STROBE_WR) begin
      case (ADDRESS)
        4'h1: begin tx_ovf_d = 1'b0; rx_ovf_d = 1'b0; end
        4'h2: begin
          div_d    = DATA_IN[3:0];
          int_en_d = DATA_IN[6];
`ifdef SPI_MASTER_LOOPBACK_EN
          loop_d   = DATA_IN[7];
`endif
        end
        4'h3:    cs_d = DATA_IN[0];
        default: ;
      endcase
    end
    // A fresh overflow wins over a same-cycle clear.
    if (wr_data && !tx_push) tx_ovf_d = 1'b1;
    if (rx_req && !rx_push)  rx_ovf_d = 1'b1;

    if (rx_pop) rx_hold_d = rx_mem[rx_rptr_q];

    tx_wptr_d = tx_push ? tx_wptr_q + AW'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + AW'(1) : tx_rptr_q;
    tx_cnt_d  = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    rx_wptr_d = rx_push ? rx_wptr_q + AW'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop  ? rx_rptr_q + AW'(1) : rx_rptr_q;
    rx_cnt_d  = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);

    int_d = int_en_q & (!rx_empty | tx_ovf_q | rx_ovf_q);
  end

  // NOTE: FIFO storage has no reset; clearing the pointers and counts is what empties it.
  always_ff @(posedge CORE_CLK) begin
    if (tx_push) tx_mem[tx_wptr_q] <= DATA_IN;
    if (rx_push) rx_mem[rx_wptr_q] <= rx_sh_q;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CORE_CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;  tx_sh_q <= '0;  rx_sh_q <= '0;  rx_hold_q <= '0;
      bit_cnt_q <= '0;  hcnt_q <= '0;  div_lat_q <= '0;  div_q <= DIV_RESET;
      sclk_q <= 1'b0;  mosi_q <= 1'b0;  cs_q <= 1'b0;  int_en_q <= 1'b0;
      tx_ovf_q <= 1'b0;  rx_ovf_q <= 1'b0;  int_q <= 1'b0;
      tx_wptr_q <= '0;  tx_rptr_q <= '0;  tx_cnt_q <= '0;
      rx_wptr_q <= '0;  rx_rptr_q <= '0;  rx_cnt_q <= '0;
`ifdef SPI_MASTER_LOOPBACK_EN
      loop_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;  tx_sh_q <= tx_sh_d;  rx_sh_q <= rx_sh_d;  rx_hold_q <= rx_hold_d;
      bit_cnt_q <= bit_cnt_d;  hcnt_q <= hcnt_d;  div_lat_q <= div_lat_d;  div_q <= div_d;
      sclk_q <= sclk_d;  mosi_q <= mosi_d;  cs_q <= cs_d;  int_en_q <= int_en_d;
      tx_ovf_q <= tx_ovf_d;  rx_ovf_q <= rx_ovf_d;  int_q <= int_d;
      tx_wptr_q <= tx_wptr_d;  tx_rptr_q <= tx_rptr_d;  tx_cnt_q <= tx_cnt_d;
      rx_wptr_q <= rx_wptr_d;  rx_rptr_q <= rx_rptr_d;  rx_cnt_q <= rx_cnt_d;
`ifdef SPI_MASTER_LOOPBACK_EN
      loop_q <= loop_d;
`endif
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Directed self-checking bench for spi_master: register map, mode-0 timing,
// FIFO overflow, interrupt and asynchronous reset mid-transfer.
module tb_spi_master;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] din = '0;
  logic [7:0] dout;
  logic       wr_s = 1'b0, rd_s = 1'b0;
  logic       sclk, mosi, miso, cs_n, irq;

  int checks = 0;
  int errors = 0;

  spi_master dut (
    .CORE_CLK (clk),   .RST_n    (rst_n),
    .ADDRESS  (addr),  .DATA_IN  (din),   .DATA_OUT (dout),
    .STROBE_WR(wr_s),  .STROBE_RD(rd_s),
    .SPI_SCLK (sclk),  .SPI_MOSI (mosi),  .SPI_MISO (miso),
    .SPI_CS_n (cs_n),  .SPI_INT  (irq)
  );

  always #5 clk = ~clk;

  // Mode-0 slave: presents pattern MSB first, advancing on each falling SCLK.
  logic [7:0] miso_pat = 8'h00;
  logic [2:0] miso_idx = 3'd0;
  assign miso = miso_pat[3'd7 - miso_idx];
  always @(negedge sclk) miso_idx = miso_idx + 3'd1;

  // Record MOSI and time at every rising SCLK edge.
  logic    rise_bit [256];
  longint  rise_t   [256];
  int      rise_cnt = 0;
  always @(posedge sclk) begin
    if (rise_cnt < 256) begin
      rise_bit[rise_cnt] = mosi;
      rise_t[rise_cnt]   = $time;
    end
    rise_cnt = rise_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); addr = a; din = d; wr_s = 1'b1;
    @(negedge clk); wr_s = 1'b0;
  endtask

  task automatic prefetch();
    @(negedge clk); addr = 4'h0; rd_s = 1'b1;
    @(negedge clk); rd_s = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] a, input logic [7:0] exp, input string tag);
    addr = a; #1;
    check(tag, 32'(dout), 32'(exp));
  endtask

  task automatic wait_idle(input int max, output int cyc);
    cyc = 0; addr = 4'h1; #1;
    while (dout[0] && cyc < max) begin
      @(negedge clk); #1; cyc++;
    end
  endtask

  function automatic logic [7:0] mosi_byte(input int base);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[7-i] = rise_bit[base+i];
    return m;
  endfunction

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, cyc;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_sclk", 32'(sclk), 32'h0);
    check("rst_mosi", 32'(mosi), 32'h0);
    check("rst_cs_n", 32'(cs_n), 32'h1);
    check("rst_int",  32'(irq),  32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk(4'h0, 8'h00, "rst_data");
    rd_chk(4'h1, 8'h0C, "rst_status");
    rd_chk(4'h2, 8'h03, "rst_ctrl");
    rd_chk(4'h3, 8'h00, "rst_cs");
    rd_chk(4'h5, 8'hEE, "unmapped_rd");
    wr(4'h5, 8'h55);
    rd_chk(4'h5, 8'hEE, "unmapped_wr");

    // One byte at DIV=0: MOSI A5 out, MISO 3C in
    wr(4'h3, 8'h01);
    check("cs_on", 32'(cs_n), 32'h0);
    rd_chk(4'h3, 8'h01, "cs_reg");
    wr(4'h2, 8'h00);
    miso_pat = 8'h3C;
    base = rise_cnt;
    wr(4'h0, 8'hA5);
    wait_idle(200, cyc);
    check("byte_cycles", 32'(cyc), 32'd18);
    check("sclk_pulses", 32'(rise_cnt - base), 32'd8);
    check("mosi_a5", 32'(mosi_byte(base)), 32'hA5);
    check("sclk_period_d0", 32'(rise_t[base+1] - rise_t[base]), 32'd20);
    prefetch();
    rd_chk(4'h0, 8'h3C, "rx_3c");
    rd_chk(4'h1, 8'h0C, "status_after_pop");

    // DIV=3, five back-to-back bytes, no reads: RX overflow on the fifth
    wr(4'h2, 8'h03);
    miso_pat = 8'h96;
    base = rise_cnt;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); addr = 4'h0; din = 8'(i); wr_s = 1'b1;
    end
    @(negedge clk); wr_s = 1'b0;
    wait_idle(1000, cyc);
    check("idle_after_5", 32'(dout[0]), 32'h0);
    check("pulses_5", 32'(rise_cnt - base), 32'd40);
    check("sclk_period_d3", 32'(rise_t[base+1] - rise_t[base]), 32'd80);
    check("byte_gap_load", 32'(rise_t[base+8] - rise_t[base+7]), 32'd90);
    rd_chk(4'h1, 8'h54, "status_rx_ovf");
    for (int i = 0; i < 4; i++) begin
      prefetch();
      rd_chk(4'h0, 8'h96, "rx_96");
    end
    rd_chk(4'h1, 8'h4C, "status_rx_drained");
    wr(4'h1, 8'h00);
    rd_chk(4'h1, 8'h0C, "status_ovf_clr");

    // DIV=15, six back-to-back pushes: LOAD pops one, the sixth is dropped
    wr(4'h2, 8'h0F);
    base = rise_cnt;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); addr = 4'h0; din = 8'hF0 + 8'(i); wr_s = 1'b1;
    end
    @(negedge clk); wr_s = 1'b0;
    rd_chk(4'h1, 8'h2B, "status_tx_ovf");
    wr(4'h1, 8'h00);
    rd_chk(4'h1, 8'h0B, "status_tx_ovf_clr");

    // Asynchronous reset during the 4th SCLK high phase
    cyc = 0;
    while (rise_cnt < base + 4 && cyc < 3000) begin
      @(negedge clk); cyc++;
    end
    check("reach_4th_rise", 32'(rise_cnt - base), 32'd4);
    check("pre_rst_sclk", 32'(sclk), 32'h1);
    check("pre_rst_mosi", 32'(mosi), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sclk", 32'(sclk), 32'h0);
    check("arst_mosi", 32'(mosi), 32'h0);
    check("arst_cs_n", 32'(cs_n), 32'h1);
    check("arst_int",  32'(irq),  32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    rd_chk(4'h1, 8'h0C, "post_rst_status");
    rd_chk(4'h2, 8'h03, "post_rst_ctrl");
    rd_chk(4'h3, 8'h00, "post_rst_cs");
    repeat (5) @(negedge clk);
    check("post_rst_no_sclk", 32'(rise_cnt - base), 32'd4);

    // Interrupt on RX data, cleared by prefetch
    wr(4'h2, 8'h40);
    wr(4'h0, 8'h11);
    wait_idle(200, cyc);
    check("byte_cycles_int", 32'(cyc), 32'd18);
    @(negedge clk);
    check("int_set", 32'(irq), 32'h1);
    prefetch();
    @(negedge clk);
    check("int_clr", 32'(irq), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
